// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability-count debouncer,
// press/release/long-press strobes and a wrapping press counter.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 100000000
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic       BTN,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_press,
   output logic [7:0] press_count
);

   localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
   localparam logic [26:0] HOLD_LAST = 27'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED = 2'b00,
      PRESSED  = 2'b01,
      HELD     = 2'b10
   } state_t;

   logic        sync_meta_r;
   logic        sync_r;
   logic [23:0] db_cnt_r;
   logic        btn_level_r;
   logic        differ_s;
   logic        accept_s;
   logic        rise_s;
   logic        fall_s;

   state_t      state_r;
   state_t      state_s;
   logic [26:0] hold_cnt_r;
   logic [26:0] hold_cnt_s;
   logic        press_pulse_r;
   logic        press_pulse_s;
   logic        release_pulse_r;
   logic        release_pulse_s;
   logic        long_press_r;
   logic        long_press_s;
   logic [7:0]  press_count_r;
   logic [7:0]  press_count_s;

   // Two-flop synchronizer for the asynchronous button input
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync_meta_r <= 1'b0;
         sync_r      <= 1'b0;
      end else begin
         sync_meta_r <= BTN;
         sync_r      <= sync_meta_r;
      end
   end

   assign differ_s = (sync_r != btn_level_r);
   assign accept_s = differ_s && (db_cnt_r == DB_LAST);
   assign rise_s   = accept_s && sync_r;
   assign fall_s   = accept_s && !sync_r;

   // Stability counter: any return to the current level restarts the count
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         db_cnt_r    <= 24'd0;
         btn_level_r <= 1'b0;
      end else if (!differ_s) begin
         db_cnt_r    <= 24'd0;
      end else if (accept_s) begin
         db_cnt_r    <= 24'd0;
         btn_level_r <= sync_r;
      end else begin
         db_cnt_r    <= db_cnt_r + 24'd1;
      end
   end

   // Press-state next-state and strobe decode; release beats long-press
   always_comb begin
      state_s         = state_r;
      hold_cnt_s      = hold_cnt_r;
      press_pulse_s   = 1'b0;
      release_pulse_s = 1'b0;
      long_press_s    = 1'b0;
      press_count_s   = press_count_r;
      case (state_r)
         RELEASED: begin
            if (rise_s) begin
               state_s       = PRESSED;
               hold_cnt_s    = 27'd0;
               press_pulse_s = 1'b1;
               press_count_s = press_count_r + 8'd1;
            end else begin
               state_s       = RELEASED;
            end
         end
         PRESSED: begin
            if (fall_s) begin
               state_s         = RELEASED;
               release_pulse_s = 1'b1;
            end else if (hold_cnt_r == HOLD_LAST) begin
               state_s         = HELD;
               long_press_s    = 1'b1;
            end else begin
               hold_cnt_s      = hold_cnt_r + 27'd1;
            end
         end
         HELD: begin
            if (fall_s) begin
               state_s         = RELEASED;
               release_pulse_s = 1'b1;
            end else begin
               state_s         = HELD;
            end
         end
         default: begin
            state_s = RELEASED;
         end
      endcase
   end

   // State, hold counter and registered outputs
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_r         <= RELEASED;
         hold_cnt_r      <= 27'd0;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         long_press_r    <= 1'b0;
         press_count_r   <= 8'd0;
      end else begin
         state_r         <= state_s;
         hold_cnt_r      <= hold_cnt_s;
         press_pulse_r   <= press_pulse_s;
         release_pulse_r <= release_pulse_s;
         long_press_r    <= long_press_s;
         press_count_r   <= press_count_s;
      end
   end

   assign btn_level     = btn_level_r;
   assign press_pulse   = press_pulse_r;
   assign release_pulse = release_pulse_r;
   assign long_press    = long_press_r;
   assign press_count   = press_count_r;

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=16; expected cycle offsets are hand-derived constants.
module tb_button_debounce;

   logic       CLK100MHZ;
   logic       CPU_RESETN;
   logic       BTN;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_press;
   logic [7:0] press_count;

   int n_checks;
   int n_fail;
   int cyc;
   int n_press, n_rel, n_long, n_overlap;
   int last_press, last_rel, last_long;
   int t0, t1, p0, r0, l0;

   button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(16)) dut (
      .CLK100MHZ    (CLK100MHZ),
      .CPU_RESETN   (CPU_RESETN),
      .BTN          (BTN),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_press   (long_press),
      .press_count  (press_count)
   );

   initial CLK100MHZ = 1'b0;
   always #5 CLK100MHZ = ~CLK100MHZ;

   // Cycle counter
   always @(posedge CLK100MHZ) cyc <= cyc + 1;

   // Strobe monitor, sampled away from the active edge
   always @(negedge CLK100MHZ) begin
      if (press_pulse) begin
         n_press    <= n_press + 1;
         last_press <= cyc;
      end
      if (release_pulse) begin
         n_rel    <= n_rel + 1;
         last_rel <= cyc;
      end
      if (long_press) begin
         n_long    <= n_long + 1;
         last_long <= cyc;
      end
      if ((32'(press_pulse) + 32'(release_pulse) + 32'(long_press)) > 32'd1)
         n_overlap <= n_overlap + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK100MHZ);
      #1;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0;
      n_press = 0; n_rel = 0; n_long = 0; n_overlap = 0;
      last_press = -1; last_rel = -1; last_long = -1;
      CPU_RESETN = 1'b0;
      BTN = 1'b0;
      #3;
      check_eq("rst_level", 32'(btn_level), 32'd0);
      check_eq("rst_pulses", 32'({press_pulse, release_pulse, long_press}), 32'd0);
      check_eq("rst_count", 32'(press_count), 32'd0);
      repeat (3) tick();
      CPU_RESETN = 1'b1;
      repeat (3) tick();

      // Clean press, held 10 cycles (short hold)
      p0 = n_press; l0 = n_long; r0 = n_rel;
      BTN = 1'b1;
      repeat (5) tick();
      check_eq("clean_pre_level", 32'(btn_level), 32'd0);
      tick();
      check_eq("clean_level", 32'(btn_level), 32'd1);
      check_eq("clean_press_pulse", 32'(press_pulse), 32'd1);
      check_eq("clean_count", 32'(press_count), 32'd1);
      tick();
      check_eq("clean_pulse_width", 32'(press_pulse), 32'd0);
      repeat (3) tick();
      BTN = 1'b0;
      t1 = cyc;
      repeat (10) tick();
      check_eq("short_release_cyc", 32'(last_rel), 32'(t1 + 6));
      check_eq("short_release_n", 32'(n_rel - r0), 32'd1);
      check_eq("short_no_long", 32'(n_long - l0), 32'd0);
      check_eq("short_press_n", 32'(n_press - p0), 32'd1);
      check_eq("short_level", 32'(btn_level), 32'd0);

      // Bounce 1,0,1,0 then settle high
      p0 = n_press;
      BTN = 1'b1; tick();
      BTN = 1'b0; tick();
      BTN = 1'b1; tick();
      BTN = 1'b0; tick();
      BTN = 1'b1;
      t0 = cyc;
      repeat (10) tick();
      check_eq("bounce_press_n", 32'(n_press - p0), 32'd1);
      check_eq("bounce_press_cyc", 32'(last_press), 32'(t0 + 6));
      check_eq("bounce_count", 32'(press_count), 32'd2);
      BTN = 1'b0;
      repeat (10) tick();

      // Long hold: 40 cycles high
      p0 = n_press; l0 = n_long; r0 = n_rel;
      BTN = 1'b1;
      t0 = cyc;
      repeat (40) tick();
      BTN = 1'b0;
      t1 = cyc;
      repeat (10) tick();
      check_eq("long_press_cyc", 32'(last_press), 32'(t0 + 6));
      check_eq("long_cyc", 32'(last_long), 32'(t0 + 22));
      check_eq("long_n", 32'(n_long - l0), 32'd1);
      check_eq("long_release_cyc", 32'(last_rel), 32'(t1 + 6));
      check_eq("long_release_n", 32'(n_rel - r0), 32'd1);
      check_eq("long_count", 32'(press_count), 32'd3);

      // Reset asserted while HELD
      l0 = n_long; r0 = n_rel;
      BTN = 1'b1;
      repeat (30) tick();
      check_eq("midrst_long_n", 32'(n_long - l0), 32'd1);
      check_eq("midrst_pre_count", 32'(press_count), 32'd4);
      #2;
      CPU_RESETN = 1'b0;
      #1;
      check_eq("midrst_level", 32'(btn_level), 32'd0);
      check_eq("midrst_count", 32'(press_count), 32'd0);
      check_eq("midrst_pulses", 32'({press_pulse, release_pulse, long_press}), 32'd0);
      BTN = 1'b0;
      repeat (2) tick();
      CPU_RESETN = 1'b1;
      repeat (20) tick();
      check_eq("midrst_no_release", 32'(n_rel - r0), 32'd0);
      check_eq("midrst_post_level", 32'(btn_level), 32'd0);

      // 256 clean presses from zero: count wraps 255 -> 0
      for (int i = 1; i <= 256; i++) begin
         BTN = 1'b1;
         repeat (7) tick();
         if (i >= 254) check_eq("wrap_count", 32'(press_count), 32'(i % 256));
         BTN = 1'b0;
         repeat (7) tick();
      end

      // Button held high across reset deassertion
      CPU_RESETN = 1'b0;
      tick();
      BTN = 1'b1;
      repeat (3) tick();
      CPU_RESETN = 1'b1;
      t0 = cyc;
      repeat (5) tick();
      check_eq("across_pre_level", 32'(btn_level), 32'd0);
      tick();
      check_eq("across_level", 32'(btn_level), 32'd1);
      check_eq("across_press_pulse", 32'(press_pulse), 32'd1);
      check_eq("across_count", 32'(press_count), 32'd1);
      tick();
      check_eq("across_press_cyc", 32'(last_press), 32'(t0 + 6));
      BTN = 1'b0;
      repeat (10) tick();

      check_eq("strobe_overlap", 32'(n_overlap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100000000, the number of debounced-high cycles after which a long press is flagged (1 s at 100 MHz); legal range 2..2^27-1.
REQ-003 The block SHALL have port CLK100MHZ, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port CPU_RESETN, input, 1 bit: asynchronous reset, active-low.
REQ-005 The block SHALL have port BTN, input, 1 bit: raw, bouncing, asynchronous push-button level, 1 = pressed.
REQ-006 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on each accepted press.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on each accepted release.
REQ-009 The block SHALL have port long_press, output, 1 bit: one-cycle strobe once per press that is held for LONG_CYCLES.
REQ-010 The block SHALL have port press_count, output, 8 bits: count of accepted presses, modulo 256.

Function
REQ-011 BTN SHALL pass through a two-flop synchronizer; only the second flop output (sync) SHALL be used downstream.
REQ-012 The debounce counter SHALL clear to 0 in every cycle where sync equals btn_level, and SHALL increment in every cycle where it differs.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, the next edge SHALL load btn_level with sync and clear the counter.
REQ-014 Any glitch returning sync to btn_level before acceptance SHALL restart the count from 0 with no output activity.
REQ-015 Latency from a clean BTN edge to a btn_level change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-016 The FSM SHALL have states RELEASED, PRESSED and HELD.
- RELEASED->PRESSED on an accepted rise.
- PRESSED->HELD when the hold counter reaches LONG_CYCLES-1.
- PRESSED or HELD->RELEASED on an accepted fall.
REQ-017 press_pulse SHALL be high for exactly the first cycle in which btn_level=1.
REQ-018 release_pulse SHALL be high for exactly the first cycle in which btn_level=0 after a press.
REQ-019 The hold counter SHALL clear on entry to PRESSED, increment each PRESSED cycle, and stop in HELD.
REQ-020 long_press SHALL pulse for one cycle on the PRESSED->HELD transition, at most once per press, and never if the release is accepted first.
REQ-021 press_count SHALL increment in the same cycle as press_pulse and wrap from 255 to 0.
REQ-022 press_pulse, release_pulse and long_press SHALL never be high in the same cycle.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While CPU_RESETN=0, all of the following SHALL be 0 immediately, independent of the clock: synchronizer flops, counters, btn_level, all three pulse outputs, and press_count; the FSM SHALL be in RELEASED.
REQ-025 Reset asserted mid-press SHALL produce no release_pulse on deassertion.
REQ-026 If BTN is held at 1 across reset deassertion, it SHALL be accepted as a new press DEBOUNCE_CYCLES+2 cycles after the first clock edge with CPU_RESETN=1.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-027 Clean press: BTN 0->1 held -> btn_level=1 and press_pulse high exactly 6 cycles after the BTN edge, press_count=1.
REQ-028 Bounce: BTN toggles 1,0,1,0 on successive cycles then settles at 1 -> exactly one press_pulse, 6 cycles after settling.
REQ-029 Long hold: BTN held at 1 for 40 cycles then released -> long_press pulses once, 16 cycles after press_pulse; release_pulse 6 cycles after the BTN fall.
REQ-030 Short hold: BTN held at 1 for 10 cycles -> press_pulse and release_pulse occur, long_press never asserts.
REQ-031 Wrap: 256 clean presses -> press_count goes 255->0 on the 256th press_pulse.
REQ-032 Reset mid-hold: CPU_RESETN pulled low during HELD -> all outputs 0 asynchronously, and no release_pulse after deassertion with BTN=0.
